// File: rtl/mips_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
package mips_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LEN_HI = 3'd1,
    LEN_LO = 3'd2,
    DATA   = 3'd3,
    DONE   = 3'd4,
    ERROR  = 3'd5
  } loader_state_t;

  localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/byte_packer.sv
// Packs a byte stream big-endian into 32-bit words; word_valid pulses on the byte completing a word.
module byte_packer
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        word_valid,
  output logic [31:0] word_data
);

  logic [23:0] shift_q;
  logic [1:0]  count_q;

  // The completing byte is combined directly so the word is ready in its own handshake cycle.
  assign word_valid = byte_valid && (count_q == 2'(BYTES_PER_WORD - 1));
  assign word_data  = {shift_q, byte_data};

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      shift_q <= '0;
      count_q <= '0;
    end else if (byte_valid) begin
      shift_q <= {shift_q[15:0], byte_data};
      count_q <= count_q + 2'd1;
    end
  end

endmodule

// File: rtl/instr_loader.sv
// Boot-time loader: receives a length-prefixed byte image and writes it word by word into
// instruction memory, holding the CPU in reset until the whole image has landed.
module instr_loader
  import mips_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int INSTR_WIDTH = 32,
  parameter int ADDR_SIZE   = 1024
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   in_valid,
  input  logic [7:0]             in_data,
  output logic                   in_ready,
  output logic                   mem_write_en,
  output logic [ADDR_WIDTH-1:0]  mem_write_addr,
  output logic [INSTR_WIDTH-1:0] mem_write_data,
  output logic                   cpu_rst,
  output logic                   busy,
  output logic                   done,
  output logic                   error
);

  localparam int unsigned MAX_WORDS = ADDR_SIZE / BYTES_PER_WORD;

  // Byte handshake: a byte moves on a cycle where in_valid and in_ready are both high;
  // in_ready is a registered copy of "state is LEN_HI, LEN_LO or DATA".
  loader_state_t state_q, state_d;
  logic [7:0]    len_hi_q;
  logic [15:0]   len_q;
  logic [15:0]   word_cnt_q;
  logic [15:0]   len_rx;
  logic          start_ok;
  logic          byte_fire;
  logic          data_fire;
  logic          last_word;
  logic          word_valid;
  logic [31:0]   word_data;

  assign start_ok  = start && (state_q inside {IDLE, DONE, ERROR});
  assign byte_fire = in_valid && in_ready;
  assign data_fire = byte_fire && (state_q == DATA);
  assign len_rx    = {len_hi_q, in_data};
  assign last_word = (word_cnt_q + 16'd1) == len_q;

  byte_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .clear      (start_ok),
    .byte_valid (data_fire),
    .byte_data  (in_data),
    .word_valid (word_valid),
    .word_data  (word_data)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE, ERROR: if (start) state_d = LEN_HI;
      LEN_HI:            if (byte_fire) state_d = LEN_LO;
      LEN_LO: begin
        if (byte_fire) begin
          if (len_rx == 16'd0)                 state_d = DONE;
          else if (32'(len_rx) > MAX_WORDS)    state_d = ERROR;
          else                                 state_d = DATA;
        end
      end
      DATA:              if (word_valid && last_word) state_d = DONE;
      default:           state_d = IDLE;
    endcase
  end

  // Status outputs are registered from the next state so they change on the same edge as the FSM.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      len_hi_q       <= '0;
      len_q          <= '0;
      word_cnt_q     <= '0;
      in_ready       <= 1'b0;
      mem_write_en   <= 1'b0;
      mem_write_addr <= '0;
      mem_write_data <= '0;
      cpu_rst        <= 1'b1;
      busy           <= 1'b0;
      done           <= 1'b0;
      error          <= 1'b0;
    end else begin
      state_q      <= state_d;
      in_ready     <= state_d inside {LEN_HI, LEN_LO, DATA};
      busy         <= state_d inside {LEN_HI, LEN_LO, DATA};
      done         <= (state_d == DONE);
      error        <= (state_d == ERROR);
      cpu_rst      <= (state_d != DONE);
      mem_write_en <= 1'b0;

      if (start_ok) begin
        word_cnt_q <= '0;
        len_q      <= '0;
      end
      if (state_q == LEN_HI && byte_fire) len_hi_q <= in_data;
      if (state_q == LEN_LO && byte_fire) len_q <= len_rx;

      if (data_fire && word_valid) begin
        mem_write_en   <= 1'b1;
        mem_write_addr <= ADDR_WIDTH'({word_cnt_q, 2'b00});
        mem_write_data <= INSTR_WIDTH'(word_data);
        word_cnt_q     <= word_cnt_q + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_instr_loader.sv
// Self-checking bench for instr_loader: vector table, directed corner sequences and random images.
module tb_instr_loader;
  import mips_pkg::*;

  localparam int ADDR_WIDTH  = 32;
  localparam int INSTR_WIDTH = 32;
  localparam int ADDR_SIZE   = 1024;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   start;
  logic                   in_valid;
  logic [7:0]             in_data;
  logic                   in_ready;
  logic                   mem_write_en;
  logic [ADDR_WIDTH-1:0]  mem_write_addr;
  logic [INSTR_WIDTH-1:0] mem_write_data;
  logic                   cpu_rst;
  logic                   busy;
  logic                   done;
  logic                   error;

  int n_cmp    = 0;
  int n_fail   = 0;
  int n_writes = 0;

  logic [63:0] exp_q[$];   // {addr, data} of each expected write, in order
  logic [7:0]  img_q[$];   // byte stream of the image under test

  typedef struct {
    logic [15:0] n;
    int          data_words;
    logic        exp_done;
    logic        exp_error;
  } vec_t;

  vec_t tbl[6];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail + 1);
    $fatal(1, "watchdog");
  end

  instr_loader #(
    .ADDR_WIDTH  (ADDR_WIDTH),
    .INSTR_WIDTH (INSTR_WIDTH),
    .ADDR_SIZE   (ADDR_SIZE)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .in_valid       (in_valid),
    .in_data        (in_data),
    .in_ready       (in_ready),
    .mem_write_en   (mem_write_en),
    .mem_write_addr (mem_write_addr),
    .mem_write_data (mem_write_data),
    .cpu_rst        (cpu_rst),
    .busy           (busy),
    .done           (done),
    .error          (error)
  );

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_in_ready"}, 64'(in_ready), 64'd0);
    check({tag, "_wen"},      64'(mem_write_en), 64'd0);
    check({tag, "_waddr"},    64'(mem_write_addr), 64'd0);
    check({tag, "_wdata"},    64'(mem_write_data), 64'd0);
    check({tag, "_cpu_rst"},  64'(cpu_rst), 64'd1);
    check({tag, "_busy"},     64'(busy), 64'd0);
    check({tag, "_done"},     64'(done), 64'd0);
    check({tag, "_error"},    64'(error), 64'd0);
  endtask

  // Scoreboard: every write strobe must match the next expected {addr, data}.
  always @(negedge clk) begin
    if (mem_write_en) begin
      n_writes++;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h expected no write",
                 mem_write_addr, mem_write_data);
      end else begin
        check("write", {mem_write_addr, mem_write_data}, exp_q.pop_front());
      end
    end
  end

  // Reference model: frame = 16-bit count N, then N big-endian words written from address 0.
  function automatic void model(output bit m_done, output bit m_err);
    int n;
    n = 32'({img_q[0], img_q[1]});
    m_done = 1'b0;
    m_err  = 1'b0;
    if (n == 0) begin
      m_done = 1'b1;
    end else if (n > ADDR_SIZE / 4) begin
      m_err = 1'b1;
    end else begin
      for (int k = 0; k < n; k++) begin
        exp_q.push_back({32'(4 * k), img_q[2 + 4*k], img_q[3 + 4*k],
                         img_q[4 + 4*k], img_q[5 + 4*k]});
      end
      m_done = 1'b1;
    end
  endfunction

  // ---------------- drivers (called at a negedge, return at a negedge) ----------------
  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int waited = 0;
    if (gap > 0) begin
      in_valid = 1'b0;
      in_data  = 8'($urandom);
      repeat (gap) @(negedge clk);
    end
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      n_cmp++;
      n_fail++;
      $display("FAIL ready_timeout: got in_ready 0 expected 1 within 50 cycles");
    end
    @(negedge clk);
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_data  = 8'($urandom);
  endtask

  task automatic build_image(input logic [15:0] n, input int data_words);
    img_q.delete();
    img_q.push_back(n[15:8]);
    img_q.push_back(n[7:0]);
    for (int i = 0; i < 4 * data_words; i++) img_q.push_back(8'($urandom));
  endtask

  task automatic finish_image(input string tag, input int exp_writes);
    idle();
    repeat (3) @(negedge clk);
    check({tag, "_exp_empty"}, 64'(exp_q.size()), 64'd0);
    check({tag, "_writes"},    64'(n_writes), 64'(exp_writes));
    exp_q.delete();
  endtask

  task automatic run_image(input string tag, input int max_gap, input bit exp_done,
                           input bit exp_err, input int exp_writes);
    n_writes = 0;
    pulse_start();
    check({tag, "_busy_start"}, 64'(busy), 64'd1);
    foreach (img_q[i]) send_byte(img_q[i], int'($urandom_range(max_gap, 0)));
    idle();
    check({tag, "_done"},     64'(done), 64'(exp_done));
    check({tag, "_error"},    64'(error), 64'(exp_err));
    check({tag, "_cpu_rst"},  64'(cpu_rst), 64'(!exp_done));
    check({tag, "_busy_end"}, 64'(busy), 64'd0);
    check({tag, "_in_ready"}, 64'(in_ready), 64'd0);
    finish_image(tag, exp_writes);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bit md, me;

    tbl[0] = '{16'd0,     0,   1'b1, 1'b0};
    tbl[1] = '{16'd1,     1,   1'b1, 1'b0};
    tbl[2] = '{16'd3,     3,   1'b1, 1'b0};
    tbl[3] = '{16'd256,   256, 1'b1, 1'b0};
    tbl[4] = '{16'd257,   0,   1'b0, 1'b1};
    tbl[5] = '{16'hFFFF,  0,   1'b0, 1'b1};

    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    repeat (3) @(negedge clk);
    check_reset("reset");
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check_reset("idle");

    // Basic two-word image with write-timing checks.
    img_q = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h01, 8'h09, 8'h50, 8'h20};
    model(md, me);
    n_writes = 0;
    pulse_start();
    for (int i = 0; i < 10; i++) begin
      send_byte(img_q[i], 0);
      if (i == 5) begin
        check("basic_w0_en",   64'(mem_write_en), 64'd1);
        check("basic_w0_addr", 64'(mem_write_addr), 64'h0);
        check("basic_w0_data", 64'(mem_write_data), 64'h2008_0005);
        check("basic_w0_cpu",  64'(cpu_rst), 64'd1);
      end
    end
    idle();
    check("basic_w1_en",   64'(mem_write_en), 64'd1);
    check("basic_w1_addr", 64'(mem_write_addr), 64'h4);
    check("basic_w1_data", 64'(mem_write_data), 64'h0109_5020);
    check("basic_done",    64'(done), 64'd1);
    check("basic_cpu_rst", 64'(cpu_rst), 64'd0);
    check("basic_ready",   64'(in_ready), 64'd0);
    finish_image("basic", 2);

    // Reload from DONE: reset to CPU reasserts on the next cycle, then 0x0 is overwritten.
    pulse_start();
    check("reload_cpu_rst", 64'(cpu_rst), 64'd1);
    check("reload_done",    64'(done), 64'd0);
    check("reload_ready",   64'(in_ready), 64'd1);
    build_image(16'd1, 1);
    model(md, me);
    n_writes = 0;
    foreach (img_q[i]) send_byte(img_q[i], 0);
    idle();
    check("reload_fin_done", 64'(done), 64'd1);
    finish_image("reload", 1);

    // Length classification table (zero, small, capacity boundary, overflow).
    foreach (tbl[t]) begin
      build_image(tbl[t].n, tbl[t].data_words);
      model(md, me);
      run_image($sformatf("tbl%0d", t), 0, tbl[t].exp_done, tbl[t].exp_error, tbl[t].data_words);
    end

    // Stalls of 5 cycles between bytes, with a start pulse mid-load that must be ignored.
    build_image(16'd1, 1);
    model(md, me);
    n_writes = 0;
    pulse_start();
    foreach (img_q[i]) begin
      idle();
      for (int c = 0; c < 5; c++) begin
        start = (i == 3 && c == 2);
        @(negedge clk);
      end
      start = 1'b0;
      check($sformatf("stall_busy%0d", i), 64'(busy), 64'd1);
      send_byte(img_q[i], 0);
    end
    idle();
    check("stall_done", 64'(done), 64'd1);
    finish_image("stall", 1);

    // Reset mid-load: word 0 written, partial word 1 discarded.
    build_image(16'd3, 3);
    model(md, me);
    n_writes = 0;
    pulse_start();
    for (int i = 0; i < 8; i++) send_byte(img_q[i], 0);
    idle();
    exp_q.delete();
    rst = 1'b1;
    @(negedge clk);
    check_reset("rstmid");
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("rstmid_writes", 64'(n_writes), 64'd1);
    check_reset("rstmid_idle");

    // Reload after reset, with in_valid raised alongside start: that byte must not be taken.
    build_image(16'd1, 1);
    model(md, me);
    n_writes = 0;
    in_valid = 1'b1;
    in_data  = 8'hFF;
    pulse_start();
    check("samecyc_busy", 64'(busy), 64'd1);
    foreach (img_q[i]) send_byte(img_q[i], 0);
    idle();
    check("samecyc_done",  64'(done), 64'd1);
    check("samecyc_error", 64'(error), 64'd0);
    finish_image("samecyc", 1);

    // Random images with random stream gaps.
    for (int r = 0; r < 20; r++) begin
      int n;
      n = int'($urandom_range(6, 1));
      build_image(16'(n), n);
      model(md, me);
      run_image($sformatf("rand%0d", r), 3, md, me, n);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
